imem_responder: RTL and testbench

- Instruction-side memory that answers the fetch unit's address requests.
- Receives the fetch address and returns the instruction word in the same cycle, combinationally.
- Before execution, a loader FSM fills the memory from a byte-serial program stream.
- `busy` freezes the pipeline while loading. Fetches outside the loaded program return a NOP (all zeros) and raise `fetch_fault`.

---
 rtl/imem_responder.sv | 153 +++++++++++++++
 tb/tb_imem_responder.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// Instruction memory with combinational fetch port and a byte-serial program loader.
// LOAD assembles little-endian words from the byte stream; RUN serves fetches from loaded words.
module imem_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_3000,
   parameter int unsigned DEPTH_WORDS = 4096,
   parameter int unsigned IDX_W       = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      i_inst_addr,
   output logic [31:0]      i_inst_rdata,
   output logic             fetch_fault,
   output logic             busy,
   input  logic             load_valid,
   input  logic [7:0]       load_byte,
   input  logic             load_last,
   output logic             load_ready,
   input  logic             reload,
   output logic             load_done,
   output logic [IDX_W:0]   words_loaded
);

   if (IDX_W != $clog2(DEPTH_WORDS)) begin : g_param_check
      $error("IDX_W must equal log2(DEPTH_WORDS)");
   end

   localparam logic [IDX_W:0] DepthCnt = (IDX_W + 1)'(DEPTH_WORDS);
   localparam logic [IDX_W:0] LastIdx  = DepthCnt - 1'b1;

   typedef enum logic [0:0] {StLoad, StRun} state_e;

   state_e         state_q, state_d;
   logic [1:0]     byte_cnt_q, byte_cnt_d;
   logic [IDX_W:0] word_ptr_q, word_ptr_d;
   logic [23:0]    asm_q, asm_d;
   logic [31:0]    mem_q [DEPTH_WORDS];

   logic           accept;
   logic           word_done;
   logic [31:0]    wdata;
   logic [31:0]    off;
   logic [IDX_W-1:0] idx;
   logic           hit;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StLoad;
         byte_cnt_q <= '0;
         word_ptr_q <= '0;
         asm_q      <= '0;
      end else begin
         state_q    <= state_d;
         byte_cnt_q <= byte_cnt_d;
         word_ptr_q <= word_ptr_d;
         asm_q      <= asm_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad: begin
            if (word_done && (load_last || word_ptr_q == LastIdx)) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (reload) begin
               state_d = StLoad;
            end
         end
         default: state_d = StLoad;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      busy       = 1'b0;
      load_ready = 1'b0;
      load_done  = 1'b0;
      unique case (state_q)
         StLoad: begin
            busy       = 1'b1;
            load_ready = (word_ptr_q < DepthCnt);
         end
         StRun: begin
            load_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign words_loaded = word_ptr_q;

   // ---------------------------------------------------------------- word assembly
   assign accept    = load_valid & load_ready;
   assign word_done = accept & ((byte_cnt_q == 2'd3) | load_last);

   // Unfilled upper lanes are already zero because asm_q clears after every write.
   always_comb begin
      wdata = {8'h00, asm_q};
      unique case (byte_cnt_q)
         2'd0: wdata[7:0]   = load_byte;
         2'd1: wdata[15:8]  = load_byte;
         2'd2: wdata[23:16] = load_byte;
         2'd3: wdata[31:24] = load_byte;
         default: ;
      endcase
   end

   always_comb begin
      asm_d      = asm_q;
      byte_cnt_d = byte_cnt_q;
      word_ptr_d = word_ptr_q;
      if (state_q == StRun) begin
         if (reload) begin
            asm_d      = '0;
            byte_cnt_d = '0;
            word_ptr_d = '0;
         end
      end else if (word_done) begin
         asm_d      = '0;
         byte_cnt_d = '0;
         word_ptr_d = word_ptr_q + 1'b1;
      end else if (accept) begin
         asm_d      = wdata[23:0];
         byte_cnt_d = byte_cnt_q + 2'd1;
      end
   end

   // Array is deliberately not reset; validity is tracked by word_ptr_q alone.
   always_ff @(posedge clk) begin
      if (!reset && word_done) begin
         mem_q[word_ptr_q[IDX_W-1:0]] <= wdata;
      end
   end

   // ---------------------------------------------------------------- fetch port
   assign off = i_inst_addr - BASE_ADDR;
   assign idx = off[IDX_W+1:2];

   always_comb begin
      hit = (state_q == StRun)
            && (i_inst_addr >= BASE_ADDR)
            && (i_inst_addr[1:0] == 2'b00)
            && ((off >> 2) < 32'(word_ptr_q));
      i_inst_rdata = hit ? mem_q[idx] : 32'h0;
      fetch_fault  = (state_q == StRun) && !hit;
   end

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: default-depth instance plus a 4-word instance for capacity.
module tb_imem_responder;

   logic        clk;
   logic        reset;
   logic [31:0] i_inst_addr;
   logic [31:0] i_inst_rdata;
   logic        fetch_fault;
   logic        busy;
   logic        load_valid;
   logic [7:0]  load_byte;
   logic        load_last;
   logic        load_ready;
   logic        reload;
   logic        load_done;
   logic [12:0] words_loaded;

   logic [31:0] s_addr;
   logic [31:0] s_rdata;
   logic        s_fault;
   logic        s_busy;
   logic        s_valid;
   logic [7:0]  s_byte;
   logic        s_last;
   logic        s_ready;
   logic        s_reload;
   logic        s_done;
   logic [2:0]  s_words;

   int n_vec = 0;
   int n_err = 0;

   imem_responder dut (
      .clk          (clk),
      .reset        (reset),
      .i_inst_addr  (i_inst_addr),
      .i_inst_rdata (i_inst_rdata),
      .fetch_fault  (fetch_fault),
      .busy         (busy),
      .load_valid   (load_valid),
      .load_byte    (load_byte),
      .load_last    (load_last),
      .load_ready   (load_ready),
      .reload       (reload),
      .load_done    (load_done),
      .words_loaded (words_loaded)
   );

   imem_responder #(
      .BASE_ADDR   (32'h0000_3000),
      .DEPTH_WORDS (4),
      .IDX_W       (2)
   ) dut_s (
      .clk          (clk),
      .reset        (reset),
      .i_inst_addr  (s_addr),
      .i_inst_rdata (s_rdata),
      .fetch_fault  (s_fault),
      .busy         (s_busy),
      .load_valid   (s_valid),
      .load_byte    (s_byte),
      .load_last    (s_last),
      .load_ready   (s_ready),
      .reload       (s_reload),
      .load_done    (s_done),
      .words_loaded (s_words)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic send(input logic [7:0] b, input logic last);
      @(negedge clk);
      load_valid = 1'b1;
      load_byte  = b;
      load_last  = last;
   endtask

   task automatic idle();
      @(negedge clk);
      load_valid = 1'b0;
      load_last  = 1'b0;
   endtask

   task automatic do_reload();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      i_inst_addr = 32'h3000;
      #1;
      n_vec++;
      if ({busy, load_ready, load_done, fetch_fault} !== 4'b1100) begin
         n_err++;
         $display("FAIL reset_flags got=%b want=1100", {busy, load_ready, load_done, fetch_fault});
      end
      n_vec++;
      if (words_loaded !== 13'd0 || i_inst_rdata !== 32'h0) begin
         n_err++;
         $display("FAIL reset_vals words=%0d rdata=%h want 0/0", words_loaded, i_inst_rdata);
      end
      n_vec++;
      if ({s_busy, s_ready, s_done, s_words} !== 6'b110_000) begin
         n_err++;
         $display("FAIL reset_small got=%b want=110000", {s_busy, s_ready, s_done, s_words});
      end
   endtask

   task automatic test_basic_load();
      logic [7:0] bytes [8];
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      for (int i = 0; i < 8; i++) begin
         send(bytes[i], i == 7);
         n_vec++;
         if (busy !== 1'b1 || load_done !== 1'b0) begin
            n_err++;
            $display("FAIL basic_busy byte=%0d busy=%b done=%b want 1/0", i, busy, load_done);
         end
      end
      idle();
      n_vec++;
      if (words_loaded !== 13'd2 || {load_done, busy, load_ready} !== 3'b100) begin
         n_err++;
         $display("FAIL basic_done words=%0d flags=%b want 2/100", words_loaded,
                  {load_done, busy, load_ready});
      end
      i_inst_addr = 32'h3000;
      #1;
      n_vec++;
      if (i_inst_rdata !== 32'h44332211 || fetch_fault !== 1'b0) begin
         n_err++;
         $display("FAIL basic_w0 got=%h/%b want=44332211/0", i_inst_rdata, fetch_fault);
      end
      i_inst_addr = 32'h3004;
      #1;
      n_vec++;
      if (i_inst_rdata !== 32'h88776655 || fetch_fault !== 1'b0) begin
         n_err++;
         $display("FAIL basic_w1 got=%h/%b want=88776655/0", i_inst_rdata, fetch_fault);
      end
   endtask

   task automatic test_reload_partial();
      logic [7:0] bytes [6];
      bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
      do_reload();
      i_inst_addr = 32'h3000;
      #1;
      n_vec++;
      if ({busy, load_done, fetch_fault} !== 3'b100 || i_inst_rdata !== 32'h0
          || words_loaded !== 13'd0) begin
         n_err++;
         $display("FAIL reload_state flags=%b rdata=%h words=%0d want 100/0/0",
                  {busy, load_done, fetch_fault}, i_inst_rdata, words_loaded);
      end
      for (int i = 0; i < 6; i++) send(bytes[i], i == 5);
      idle();
      n_vec++;
      if (words_loaded !== 13'd2 || load_done !== 1'b1) begin
         n_err++;
         $display("FAIL partial_words got=%0d/%b want=2/1", words_loaded, load_done);
      end
      i_inst_addr = 32'h3004;
      #1;
      n_vec++;
      if (i_inst_rdata !== 32'h0000FFEE || fetch_fault !== 1'b0) begin
         n_err++;
         $display("FAIL partial_pad got=%h/%b want=0000ffee/0", i_inst_rdata, fetch_fault);
      end
      i_inst_addr = 32'h3008;
      #1;
      n_vec++;
      if (i_inst_rdata !== 32'h0 || fetch_fault !== 1'b1) begin
         n_err++;
         $display("FAIL partial_beyond got=%h/%b want=0/1", i_inst_rdata, fetch_fault);
      end
   endtask

   task automatic test_fault_addrs();
      logic [31:0] addrs [5];
      logic [32:0] want  [5];
      addrs = '{32'h2FFC, 32'h3002, 32'h3000, 32'hFFFF_FFFC, 32'h0000_0000};
      want  = '{{1'b1, 32'h0}, {1'b1, 32'h0}, {1'b0, 32'hDDCCBBAA}, {1'b1, 32'h0},
                {1'b1, 32'h0}};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         i_inst_addr = addrs[i];
         #1;
         n_vec++;
         if ({fetch_fault, i_inst_rdata} !== want[i]) begin
            n_err++;
            $display("FAIL fault_addr a=%h got=%b/%h want=%b/%h", addrs[i], fetch_fault,
                     i_inst_rdata, want[i][32], want[i][31:0]);
         end
      end
   endtask

   task automatic test_gaps();
      logic [7:0] bytes [8];
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      do_reload();
      for (int i = 0; i < 8; i++) begin
         send(bytes[i], i == 7);
         if (i != 7) begin
            for (int g = 0; g < 2; g++) begin
               idle();
               n_vec++;
               if (words_loaded !== 13'((i + 1) / 4) || busy !== 1'b1) begin
                  n_err++;
                  $display("FAIL gap_hold byte=%0d words=%0d busy=%b want=%0d/1", i,
                           words_loaded, busy, (i + 1) / 4);
               end
            end
         end
      end
      idle();
      i_inst_addr = 32'h3000;
      #1;
      n_vec++;
      if (i_inst_rdata !== 32'h44332211 || words_loaded !== 13'd2) begin
         n_err++;
         $display("FAIL gap_w0 got=%h words=%0d want=44332211/2", i_inst_rdata, words_loaded);
      end
      i_inst_addr = 32'h3004;
      #1;
      n_vec++;
      if (i_inst_rdata !== 32'h88776655) begin
         n_err++;
         $display("FAIL gap_w1 got=%h want=88776655", i_inst_rdata);
      end
   endtask

   task automatic test_mid_reset();
      do_reload();
      for (int i = 0; i < 5; i++) send(8'hC0 + 8'(i), 1'b0);
      @(negedge clk);
      load_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_vec++;
      if (words_loaded !== 13'd0 || busy !== 1'b1 || load_done !== 1'b0) begin
         n_err++;
         $display("FAIL midreset words=%0d busy=%b done=%b want=0/1/0", words_loaded, busy,
                  load_done);
      end
      for (int i = 0; i < 4; i++) send(8'(i + 1), i == 3);
      idle();
      i_inst_addr = 32'h3000;
      #1;
      n_vec++;
      if (i_inst_rdata !== 32'h04030201 || words_loaded !== 13'd1) begin
         n_err++;
         $display("FAIL midreset_word got=%h words=%0d want=04030201/1", i_inst_rdata,
                  words_loaded);
      end
      i_inst_addr = 32'h3004;
      #1;
      n_vec++;
      if (fetch_fault !== 1'b1) begin
         n_err++;
         $display("FAIL midreset_beyond fault=%b want=1", fetch_fault);
      end
   endtask

   task automatic test_single_byte();
      do_reload();
      send(8'h5A, 1'b1);
      idle();
      i_inst_addr = 32'h3000;
      #1;
      n_vec++;
      if (i_inst_rdata !== 32'h0000005A || words_loaded !== 13'd1 || load_done !== 1'b1) begin
         n_err++;
         $display("FAIL single_byte got=%h words=%0d done=%b want=0000005a/1/1", i_inst_rdata,
                  words_loaded, load_done);
      end
   endtask

   task automatic test_capacity();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         n_vec++;
         if (s_ready !== (i < 16)) begin
            n_err++;
            $display("FAIL cap_ready byte=%0d got=%b want=%b", i + 1, s_ready, i < 16);
         end
         s_valid = 1'b1;
         s_byte  = 8'(i + 1);
      end
      @(negedge clk);
      s_valid = 1'b0;
      n_vec++;
      if (s_words !== 3'd4 || s_done !== 1'b1 || s_busy !== 1'b0) begin
         n_err++;
         $display("FAIL cap_done words=%0d done=%b busy=%b want=4/1/0", s_words, s_done, s_busy);
      end
      s_addr = 32'h3000;
      #1;
      n_vec++;
      if (s_rdata !== 32'h04030201 || s_fault !== 1'b0) begin
         n_err++;
         $display("FAIL cap_w0 got=%h/%b want=04030201/0", s_rdata, s_fault);
      end
      s_addr = 32'h300C;
      #1;
      n_vec++;
      if (s_rdata !== 32'h100F0E0D || s_fault !== 1'b0) begin
         n_err++;
         $display("FAIL cap_w3 got=%h/%b want=100f0e0d/0", s_rdata, s_fault);
      end
      s_addr = 32'h3010;
      #1;
      n_vec++;
      if (s_rdata !== 32'h0 || s_fault !== 1'b1) begin
         n_err++;
         $display("FAIL cap_beyond got=%h/%b want=0/1", s_rdata, s_fault);
      end
   endtask

   initial begin
      reset       = 1'b1;
      i_inst_addr = 32'h0;
      load_valid  = 1'b0;
      load_byte   = 8'h0;
      load_last   = 1'b0;
      reload      = 1'b0;
      s_addr      = 32'h0;
      s_valid     = 1'b0;
      s_byte      = 8'h0;
      s_last      = 1'b0;
      s_reload    = 1'b0;
      test_reset();
      test_basic_load();
      test_reload_partial();
      test_fault_addrs();
      test_gaps();
      test_mid_reset();
      test_single_byte();
      test_capacity();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
